// File: rtl/cntr_pkg.sv
// Shared width and default terminal-count constants for the cntr_4 counter.
package cntr_pkg;
   localparam int                CNTR_W      = 4;
   localparam logic [CNTR_W-1:0] MAX_VAL_DEF = 4'd15;
endpackage

// File: rtl/cntr_4.sv
// Wrapping up-counter, one-cycle latency from ce to out, synchronous active-high reset.
// Terminal-count pulse is decoded only when CNTR_4_TC_EN is defined; otherwise tc is tied low.
module cntr_4
   import cntr_pkg::*;
#(
   parameter logic [CNTR_W-1:0] MAX_VAL = MAX_VAL_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   output logic [CNTR_W-1:0] out,
   output logic              tc
);

   logic [CNTR_W-1:0] r_cnt;
   logic [CNTR_W-1:0] w_cnt_nxt;
   logic              w_at_max;

   // Values above MAX_VAL (only possible before reset) keep counting modulo 16.
   always_comb begin
      w_at_max  = (r_cnt == MAX_VAL);
      w_cnt_nxt = w_at_max ? '0 : r_cnt + CNTR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (ce) begin
         r_cnt <= w_cnt_nxt;
      end
   end

   assign out = r_cnt;

`ifdef CNTR_4_TC_EN
   always_comb begin
      tc = w_at_max & ce & ~rst;
   end
`else
   assign tc = 1'b0;
`endif

endmodule

// File: tb/tb_cntr_4.sv
// Directed-vector bench for cntr_4 (default MAX_VAL and MAX_VAL=9) with a queue-based scoreboard.
module tb_cntr_4;

   typedef struct packed {
      logic [3:0] out;
      logic       tc;
      logic [3:0] out9;
      logic       tc9;
   } exp_t;

`ifdef CNTR_4_TC_EN
   localparam bit TC_ON = 1'b1;
`else
   localparam bit TC_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, ce, rst9, ce9;
   logic [3:0] out, out9;
   logic       tc, tc9;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   n_step   = 0;
   bit   started  = 1'b0;

   cntr_4 dut (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .out (out),
      .tc  (tc)
   );

   cntr_4 #(.MAX_VAL(4'd9)) dut9 (
      .clk (clk),
      .rst (rst9),
      .ce  (ce9),
      .out (out9),
      .tc  (tc9)
   );

   // Rising edges at 5, 15, 25 ns ...
   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s step=%0d got=%0h want=%0h", name, idx, act, req);
      end
   endtask

   // Inputs change on the falling edge; the entry holds tc for the coming cycle and out after its edge.
   task automatic step(input logic r, input logic c, input logic [3:0] eo, input logic etc,
                       input logic r9, input logic c9, input logic [3:0] eo9, input logic etc9);
      exp_t e;
      if (started) @(negedge clk);
      started = 1'b1;
      rst  = r;
      ce   = c;
      rst9 = r9;
      ce9  = c9;
      e.out  = eo;
      e.tc   = etc;
      e.out9 = eo9;
      e.tc9  = etc9;
      q.push_back(e);
   endtask

   task automatic stepm(input logic r, input logic c, input logic [3:0] eo, input logic etc);
      step(r, c, eo, etc, 1'b1, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic step9(input logic c9, input logic [3:0] eo9, input logic etc9);
      step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, c9, eo9, etc9);
   endtask

   // Monitor: tc sampled 2 ns before each rising edge, out 1 ns after it.
   initial begin
      logic tc_s, tc9_s;
      exp_t e;
      int   idx;
      idx = 0;
      #3;
      forever begin
         tc_s  = tc;
         tc9_s = tc9;
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("out",  idx, out,  e.out);
            chk("tc",   idx, {3'b0, tc_s},  {3'b0, TC_ON ? e.tc : 1'b0});
            chk("out9", idx, out9, e.out9);
            chk("tc9",  idx, {3'b0, tc9_s}, {3'b0, TC_ON ? e.tc9 : 1'b0});
            idx++;
         end
         #7;
      end
   end

   initial begin
      rst = 1'b1; ce = 1'b0; rst9 = 1'b1; ce9 = 1'b0;

      // Reset, then reset held with ce high: reset wins.
      stepm(1'b1, 1'b0, 4'd0, 1'b0);
      stepm(1'b1, 1'b1, 4'd0, 1'b0);

      // Full count 0..15 and wrap to 0 on the 16th edge.
      for (int i = 0; i < 16; i++)
         stepm(1'b0, 1'b1, (i == 15) ? 4'd0 : 4'(i + 1), (i == 15));

      // Count to 7, hold for 3 edges, resume to 11.
      for (int i = 1; i <= 7; i++) stepm(1'b0, 1'b1, 4'(i), 1'b0);
      for (int i = 0; i < 3; i++)  stepm(1'b0, 1'b0, 4'd7, 1'b0);
      for (int i = 8; i <= 11; i++) stepm(1'b0, 1'b1, 4'(i), 1'b0);

      // Mid-count reset with ce high, then release.
      stepm(1'b1, 1'b1, 4'd0, 1'b0);
      stepm(1'b0, 1'b1, 4'd1, 1'b0);

      // Reach 15, hold with ce low (no tc), then ce high (tc, wrap).
      for (int i = 2; i <= 15; i++) stepm(1'b0, 1'b1, 4'(i), 1'b0);
      stepm(1'b0, 1'b0, 4'd15, 1'b0);
      stepm(1'b0, 1'b1, 4'd0, 1'b1);

      // Reach 15 again, then rst and ce together: tc suppressed.
      for (int i = 1; i <= 15; i++) stepm(1'b0, 1'b1, 4'(i), 1'b0);
      stepm(1'b1, 1'b1, 4'd0, 1'b0);

      // MAX_VAL=9 instance: 0..9, wrap to 0, then 1, then hold.
      for (int k = 0; k <= 9; k++)
         step9(1'b1, (k == 9) ? 4'd0 : 4'(k + 1), (k == 9));
      step9(1'b1, 4'd1, 1'b0);
      step9(1'b0, 4'd1, 1'b0);

      for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cntr_4.md
CNTR_4 -- requirements
Module: cntr_4

Interface
REQ-001 Parameter: MAX_VAL, default 4'd15, terminal count value; legal range 1..15.
REQ-002 Port: clk  input  1  rising-edge clock; the single clock of the block.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: ce  input  1  count enable, active-high, sampled on rising clk.
REQ-005 Port: out  output  4  current count value, registered.
REQ-006 Port: tc  output  1  terminal-count pulse, combinational from out and ce.

Function
REQ-007 out SHALL change only on rising edges of clk.
REQ-008 rst=1 at a rising edge SHALL load out=4'd0, regardless of ce.
REQ-009 With rst=0 and ce=1, out SHALL increment by 1 per rising edge.
REQ-010 With rst=0 and ce=1 and out==MAX_VAL, the next edge SHALL load out=4'd0 (wrap-around, no saturation).
REQ-011 With rst=0 and ce=0, out SHALL hold its value.
REQ-012 Latency: ce asserted before edge N SHALL be visible on out immediately after edge N (one-cycle latency, no pipelining).
REQ-013 Increment arithmetic SHALL be 4-bit unsigned; no carry is exported except via tc.
REQ-014 tc SHALL equal (out==MAX_VAL) AND ce AND NOT rst when the feature in REQ-019 is compiled in.
REQ-015 Simultaneous rst=1 and ce=1: rst SHALL win; out=0, and tc=0 in that cycle.
REQ-016 Values of out above MAX_VAL SHALL NOT be reachable after reset; if present (pre-reset X/garbage), ce=1 SHALL still increment modulo 16 until reset.

Reset
REQ-017 Reset SHALL be synchronous, active-high, and sampled only on rising clk; no asynchronous path exists.
REQ-018 Reset value: out=4'd0, tc=0; reset asserted mid-count SHALL take effect at the next rising edge.

Configuration
REQ-019 Macro CNTR_4_TC_EN: when defined, tc SHALL be driven per REQ-014; when undefined, tc SHALL be tied to 1'b0 and no compare logic is synthesized. The port list SHALL be identical in both cases.

Structure
REQ-020 A shared package cntr_pkg SHALL hold CNTR_W=4 and the default MAX_VAL constant.
REQ-021 The block SHALL be a single flat module; no sub-module is required.
REQ-022 Register update and tc decode SHALL be in separate sequential and combinational processes.

Verification
REQ-023 Reset: rst=1, ce=0 for one edge at 5 ns -> out=0 after that edge; hold rst=1 with ce=1 -> out stays 0.
REQ-024 Counting: clock period 10 ns, rst=0, ce=1 after 10 ns -> out steps 0,1,2,...,15 on successive edges, then 0 on the 16th edge.
REQ-025 Hold: out=7, ce=0 for 3 edges -> out stays 7; ce=1 again -> out=8 on the next edge.
REQ-026 Mid-count reset: out=11, rst=1 with ce=1 for one edge -> out=0; release rst -> out=1 one edge later.
REQ-027 Terminal count (CNTR_4_TC_EN defined): out=15, ce=1 -> tc=1 in that cycle and out=0 after the edge; ce=0 at out=15 -> tc=0.
REQ-028 MAX_VAL=9 build: continuous ce=1 from reset -> out sequence 0..9,0; tc=1 only while out=9.
